// File: rtl/inst_fetcher_pkg.sv
// inst_fetcher_pkg: shared types, defaults and FSM encodings for the instruction fetcher
package inst_fetcher_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [7:0] mem_byte_t;
  typedef logic [31:0] inst_t;
  localparam int INST_QUEUE_DEPTH = 4;
  typedef enum logic [2:0] {
    IF_IDLE   = 3'b000,
    IF_DRAIN  = 3'b001,
    IF_ISSUE0 = 3'b100,
    IF_ISSUE1 = 3'b101,
    IF_ISSUE2 = 3'b110,
    IF_ISSUE3 = 3'b111
  } if_state_t;
  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetcher_queue.sv
// inst_queue: circular FIFO of {pc, inst} with flush taking priority over push and pop
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int DEPTH = INST_QUEUE_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fetch_entry_t           i_data,
  input  logic                   i_pop,
  output logic                   o_valid,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_head, r_tail;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign w_push = i_push && !i_flush;
  assign w_pop = i_pop && r_count != '0 && !i_flush;
  assign o_valid = r_count != '0;
  assign o_head = r_mem[r_head];
  assign o_count = r_count;
  // pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  // entry storage needs no reset since occupancy gates visibility
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_tail] <= i_data;
  end
endmodule

// File: rtl/inst_fetcher.sv
// inst_fetcher: byte-wise instruction fetch into a small PC-tagged queue with redirect flush
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int    QUEUE_DEPTH = INST_QUEUE_DEPTH,
  parameter addr_t RESET_PC    = 32'h0
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      rdy_in,
  input  logic      mem_grant_in,
  output logic      mem_rd_req_out,
  output addr_t     mem_a_out,
  input  mem_byte_t mem_din_in,
  input  logic      redirect_in,
  input  addr_t     redirect_pc_in,
  output logic      inst_valid_out,
  output inst_t     inst_out,
  output addr_t     inst_pc_out,
  input  logic      inst_ready_in
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
  if_state_t r_state, w_next;
  addr_t r_pc;
  logic r_pend;
  logic [1:0] r_lane;
  logic [31:0] r_buf;
  logic w_issue, w_grant, w_push;
  logic [1:0] w_lane;
  logic [CW-1:0] w_count;
  fetch_entry_t w_entry, w_head;
  assign w_issue = r_state[2];
  assign w_lane = r_state[1:0];
  assign w_grant = w_issue && mem_grant_in && rdy_in && !redirect_in;
  assign w_push = r_state == IF_DRAIN && rdy_in && !redirect_in;
  assign mem_rd_req_out = w_grant;
  assign mem_a_out = w_issue ? r_pc + {30'd0, w_lane} : '0;
  assign w_entry = '{pc: r_pc, inst: {r_pend ? mem_din_in : r_buf[31:24], r_buf[23:0]}};
  assign inst_out = w_head.inst;
  assign inst_pc_out = w_head.pc;
  // state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= IF_IDLE;
    else r_state <= w_next;
  end
  // next state: redirect wins, issue states step one byte lane per granted read
  always_comb begin
    w_next = r_state;
    if (redirect_in) w_next = IF_IDLE;
    else if (r_state == IF_IDLE) w_next = (rdy_in && w_count < FULL) ? IF_ISSUE0 : IF_IDLE;
    else if (w_grant) w_next = (w_lane == 2'd3) ? IF_DRAIN : if_state_t'({1'b1, w_lane + 2'd1});
    else if (r_state == IF_DRAIN && rdy_in) w_next = IF_IDLE;
  end
  // byte capture one cycle after each granted read, and PC advance on push or redirect
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pc <= RESET_PC;
      r_pend <= 1'b0;
      r_lane <= 2'd0;
      r_buf <= '0;
    end else begin
      r_pend <= w_grant;
      if (w_grant) r_lane <= w_lane;
      if (r_pend && !redirect_in) r_buf[{r_lane, 3'b000} +: 8] <= mem_din_in;
      if (redirect_in) r_pc <= redirect_pc_in;
      else if (w_push) r_pc <= r_pc + 32'd4;
    end
  end
  inst_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_flush (redirect_in),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (inst_ready_in),
    .o_valid (inst_valid_out),
    .o_head  (w_head),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_inst_fetcher.sv
// tb_inst_fetcher: scoreboard bench for inst_fetcher with a byte memory model
module tb_inst_fetcher;
  logic clk_in = 0, rst_in = 1, rdy_in = 0, mem_grant_in = 0, redirect_in = 0, inst_ready_in = 0;
  logic [7:0] mem_din_in = 8'h00;
  logic [31:0] redirect_pc_in = 32'h0;
  logic mem_rd_req_out, inst_valid_out;
  logic [31:0] mem_a_out, inst_out, inst_pc_out;
  inst_fetcher #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_grant_in(mem_grant_in),
    .mem_rd_req_out(mem_rd_req_out), .mem_a_out(mem_a_out), .mem_din_in(mem_din_in),
    .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in), .inst_valid_out(inst_valid_out),
    .inst_out(inst_out), .inst_pc_out(inst_pc_out), .inst_ready_in(inst_ready_in)
  );
  always #5 clk_in = ~clk_in;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];
  int tests = 0, fails = 0, pops = 0;
  function automatic logic [7:0] byte_at(input logic [31:0] a);
    case (a)
      32'h0: return 8'h13;
      32'h1: return 8'h05;
      32'h2: return 8'h10;
      32'h3: return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic expect_word(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    e.pc = pc;
    e.inst = inst;
    sb.push_back(e);
  endtask
  task automatic accept(input int n);
    int target;
    target = pops + n;
    inst_ready_in = 1;
    for (int i = 0; i < 200 && pops < target; i++) tick();
    inst_ready_in = 0;
    check("accept_count", 32'(pops), 32'(target));
  endtask
  task automatic wait_req(input logic [31:0] a, input string name);
    logic hit;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk_in);
      #2;
      hit = mem_rd_req_out && mem_a_out == a;
    end
    check(name, 32'(hit), 32'd1);
  endtask
  task automatic redirect(input logic [31:0] pc);
    redirect_pc_in = pc;
    redirect_in = 1;
    tick();
    redirect_in = 0;
  endtask
  initial begin
    logic iss;
    logic [31:0] a;
    forever begin
      @(negedge clk_in);
      #3;
      iss = mem_rd_req_out;
      a = mem_a_out;
      @(posedge clk_in);
      #1;
      mem_din_in = iss ? byte_at(a) : 8'hEE;
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (inst_valid_out && inst_ready_in) begin
        pops++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop: got pc %h, expected no word", inst_pc_out);
        end else begin
          e = sb.pop_front();
          check("pop_pc", inst_pc_out, e.pc);
          check("pop_inst", inst_out, e.inst);
        end
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int t_req, t_val, nreq;
    logic [31:0] addrs[$];
    logic [31:0] wrap_a [5];
    wrap_a = '{32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0};
    rdy_in = 1;
    mem_grant_in = 1;
    tick();
    tick();
    @(negedge clk_in);
    check("rst_valid", 32'(inst_valid_out), 0);
    check("rst_req", 32'(mem_rd_req_out), 0);
    check("rst_addr", mem_a_out, 0);
    tick();
    rst_in = 0;
    t_req = -1;
    t_val = -1;
    nreq = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_in);
      #2;
      if (t_req < 0 && mem_rd_req_out) t_req = c;
      if (t_val < 0 && inst_valid_out) t_val = c;
      if (mem_rd_req_out) nreq++;
    end
    check("valid_latency", 32'(t_val - t_req), 32'd5);
    check("full_queue_reqs", 32'(nreq), 32'd16);
    check("full_head_pc", inst_pc_out, 32'h0);
    expect_word(32'h0, 32'h00100513);
    expect_word(32'h4, 32'h5D5C5F5E);
    expect_word(32'h8, 32'h51505352);
    expect_word(32'hC, 32'h55545756);
    expect_word(32'h10, 32'h49484B4A);
    expect_word(32'h14, 32'h4D4C4F4E);
    tick();
    accept(1);
    wait_req(32'h10, "fetch_pc16_after_pop");
    tick();
    accept(5);
    mem_grant_in = 0;
    redirect(32'h200);
    tick();
    mem_grant_in = 1;
    tick();
    tick();
    mem_grant_in = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      #2;
      check("stall_addr", mem_a_out, 32'h202);
      check("stall_req", 32'(mem_rd_req_out), 0);
      tick();
    end
    mem_grant_in = 1;
    expect_word(32'h200, 32'h5B5A5958);
    accept(1);
    redirect(32'h300);
    wait_req(32'h309, "reach_issue1");
    check("pre_redirect_valid", 32'(inst_valid_out), 1);
    check("pre_redirect_head", inst_pc_out, 32'h300);
    redirect_pc_in = 32'h1000;
    redirect_in = 1;
    #1;
    check("redirect_req_low", 32'(mem_rd_req_out), 0);
    tick();
    redirect_in = 0;
    @(negedge clk_in);
    check("post_redirect_valid", 32'(inst_valid_out), 0);
    check("post_redirect_req", 32'(mem_rd_req_out), 0);
    expect_word(32'h1000, 32'h49484B4A);
    tick();
    accept(1);
    redirect(32'hFFFFFFFC);
    for (int c = 0; c < 40 && addrs.size() < 5; c++) begin
      @(negedge clk_in);
      #2;
      if (mem_rd_req_out) addrs.push_back(mem_a_out);
    end
    check("wrap_count", 32'(addrs.size()), 32'd5);
    for (int i = 0; i < addrs.size() && i < 5; i++) check("wrap_addr", addrs[i], wrap_a[i]);
    expect_word(32'hFFFFFFFC, 32'h5A5B5859);
    expect_word(32'h0, 32'h00100513);
    tick();
    accept(2);
    redirect(32'h400);
    expect_word(32'h400, 32'h5D5C5F5E);
    expect_word(32'h404, 32'h59585B5A);
    wait_req(32'h407, "reach_second_issue3");
    tick();
    inst_ready_in = 1;
    tick();
    inst_ready_in = 0;
    @(negedge clk_in);
    check("push_pop_valid", 32'(inst_valid_out), 1);
    check("push_pop_head", inst_pc_out, 32'h404);
    tick();
    accept(1);
    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
Front-end producer of raw 32-bit instruction words for the RV32I decoder. It fetches bytes from the byte-wide unified memory through the memory arbiter, assembles little-endian words, and buffers them with their PCs in a small queue. It presents them to the decode stage over a valid/ready handshake. Dispatch can redirect it on a jump or branch, which flushes all buffered and in-flight work.

Parameters:
QUEUE_DEPTH, 4, instruction queue entries; must be a power of two and at least 2.
RESET_PC, 32'h0, PC loaded at reset.

Ports:
clk_in  input  1  clock, all state on the rising edge.
rst_in  input  1  asynchronous, active-high reset.
rdy_in  input  1  global ready; low suppresses new memory issues.
mem_grant_in  input  1  arbiter grants the memory bus to this block this cycle.
mem_rd_req_out  output  1  byte read request, asserted only when a read is actually issued.
mem_a_out  output  32  byte address of the current read.
mem_din_in  input  8  read data, valid the cycle after a granted request.
redirect_in  input  1  flush and restart fetch.
redirect_pc_in  input  32  new fetch PC, sampled when redirect_in=1.
inst_valid_out  output  1  queue head is valid.
inst_out  output  32  instruction word at the queue head (`INST_TYPE).
inst_pc_out  output  32  PC of inst_out.
inst_ready_in  input  1  decode stage accepts the head this cycle.

Behaviour:
- Reset (asynchronous): pc=RESET_PC, queue empty, state IDLE, pending=0, byte buffer 0.
  - inst_valid_out=0, mem_rd_req_out=0, mem_a_out=0.
- States:
  - IDLE: no word in flight.
  - ISSUE0..ISSUE3: issue byte k of the current word.
  - DRAIN: capture the final byte.
- Leaving IDLE:
  - IDLE -> ISSUE0 when rdy_in=1, redirect_in=0, and queue count < QUEUE_DEPTH.
  - The in-flight word reserves a slot, so a push never meets a full queue.
- Issuing:
  - In ISSUEk, mem_rd_req_out=1 and mem_a_out=pc+k (32-bit wrap).
  - The issue is granted only if mem_grant_in=1 and rdy_in=1; then the state advances, and ISSUE3 -> DRAIN.
  - Otherwise the state holds, mem_rd_req_out=0, and the address is held.
- Capture:
  - pending is set by every granted issue.
  - On the cycle after a granted issue, mem_din_in is stored into byte lane k, regardless of grant or rdy_in in that cycle.
  - Byte 0 goes to inst[7:0] and byte 3 to inst[31:24].
- Completion:
  - In DRAIN, byte 3 is captured and {b3,b2,b1,b0} is pushed with pc.
  - Then pc <= pc+4 and the state returns to IDLE.
  - A granted word costs 5 cycles; back-to-back words are not overlapped.
- Misaligned PC: no alignment check; the four bytes at pc..pc+3 are fetched.
- Queue:
  - Circular buffer with head/tail pointers wrapping modulo QUEUE_DEPTH, plus a count.
  - inst_valid_out = count != 0.
  - Pop when inst_valid_out && inst_ready_in.
  - A push and a pop in the same cycle leave count unchanged.
  - The head is stable while valid and not popped.
- Redirect (highest priority, over push, pop and issue):
  - At the edge where redirect_in=1, the queue empties, state goes to IDLE, pending is cleared, and pc <= redirect_pc_in.
  - Any byte returning on the following cycle is discarded.
  - inst_valid_out is 0 in the next cycle.
  - The first new issue comes no earlier than 1 cycle after the redirect edge.
- rdy_in=0: no new issues and the FSM does not advance; a pending capture, pops, and redirect still occur.
- mem_rd_req_out is never asserted in IDLE or DRAIN, or while redirect_in=1.

Decomposition:
- Shared header config.v gains:
  - `ADDR_TYPE [31:0]
  - `MEM_BYTE_TYPE [7:0]
  - an `INST_QUEUE_DEPTH default
  - FSM state encodings `IF_IDLE, `IF_ISSUE0..3, `IF_DRAIN
- It reuses `INST_TYPE.
- One sub-module, inst_queue: a parameterised FIFO of {pc, inst} with push/pop/flush and count.
  - Flush has priority over push.

Test Plan:
- Reset then continuous grant, ready=1: bytes at 0..3 = 13,05,10,00 -> inst_out=32'h00100513, inst_pc_out=0; inst_valid_out rises 5 cycles after the first issue.
- Hold inst_ready_in=0, grant always: exactly QUEUE_DEPTH=4 words (PCs 0,4,8,12) are queued, then mem_rd_req_out stays 0; pop one -> the fetch of PC 16 starts.
- Deassert mem_grant_in for 3 cycles during ISSUE2: mem_a_out holds at pc+2 and the word is still assembled correctly, with no duplicate or skipped bytes.
- redirect_in=1 with redirect_pc_in=32'h1000 while in ISSUE1 with 2 words queued -> next cycle inst_valid_out=0 and the late byte is discarded; first queued PC is 32'h1000.
- Redirect to 32'hFFFFFFFC -> addresses FFFFFFFC..FFFFFFFF, next PC 32'h0 (wrap).
- Simultaneous push and pop at count=1 -> count stays 1 and the head advances in order.
